// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle processor controller:
// state encoding, opcode constants, ALU operation codes and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       branch;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  // States that stall on the memory handshake.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The controller side uses the
// master modport; the datapath (or a testbench) uses the slave modport.
interface multicycle_control_if;

  logic [5:0] Opcode;
  logic       MemReady;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       PCWrite;
  logic       Branch;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, MemReady,
    output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCWrite,
           Branch, ALUSrcA, ALUSrcB, ALUOp, PCSrc, InstrDone, IllegalOp, State
  );

  modport slave (
    output Opcode, MemReady,
    input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCWrite,
           Branch, ALUSrcA, ALUSrcB, ALUOp, PCSrc, InstrDone, IllegalOp, State
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode: state plus memory handshake to control word.
// Only the memory states look at mem_ready; everything else is pure Moore.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe held through wait cycles; done only on completion.
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor main controller: state register and next-state logic;
// output strobes come from mc_ctrl_decode.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [5:0] OP_LW    = OPC_LW,
  parameter logic [5:0] OP_SW    = OPC_SW,
  parameter logic [5:0] OP_BEQ   = OPC_BEQ,
  parameter logic [5:0] OP_ADDI  = OPC_ADDI,
  parameter logic [5:0] OP_J     = OPC_J
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  state_t state_reg;
  state_t state_next;
  logic   illegal_op;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_next = state_reg;
    illegal_op = 1'b0;
    unique case (state_reg)
      S_FETCH:   state_next = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
          state_next = S_MEMADR;
        end else if (bus.Opcode == OP_RTYPE) begin
          state_next = S_EXECUTE;
        end else if (bus.Opcode == OP_BEQ) begin
          state_next = S_BRANCH;
        end else if (bus.Opcode == OP_ADDI) begin
          state_next = S_ADDIEX;
        end else if (bus.Opcode == OP_J) begin
          state_next = S_JUMP;
        end else begin
          state_next = S_FETCH;
          illegal_op = 1'b1;
        end
      end
      S_MEMADR:  state_next = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                 state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (bus.MemReady),
    .ctrl      (ctrl)
  );

  assign bus.IorD      = ctrl.iord;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.MemtoReg  = ctrl.mem_to_reg;
  assign bus.PCWrite   = ctrl.pc_write;
  assign bus.Branch    = ctrl.branch;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.PCSrc     = ctrl.pc_src;
  assign bus.InstrDone = ctrl.instr_done;
  assign bus.IllegalOp = illegal_op;
  assign bus.State     = state_reg;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_RTYPE, default 6'b000000, meaning R-type opcode.
REQ-002 SHALL have parameters OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_ADDI 6'b001000 and OP_J 6'b000010, each naming its instruction opcode.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 Opcode  in  6  instruction bits [31:26], taken from the instruction register.
REQ-007 MemReady  in  1  memory completes the current read or write this cycle.
REQ-008 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCWrite, Branch, ALUSrcA  out  1 each  datapath strobes and mux selects.
REQ-009 ALUSrcB  out  2  ALU B-operand select: 00 reg, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-010 ALUOp  out  2  code to the ALU control decoder: 00 add, 01 subtract, 10 use funct field.
REQ-011 PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 InstrDone  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-013 IllegalOp  out  1  one-cycle pulse when an undecoded opcode reaches DECODE.
REQ-014 State  out  4  current state, for debug.

Function
REQ-015 SHALL be a Moore FSM, except that gating by MemReady is Mealy; outputs not listed for a state SHALL be 0.
REQ-016 States and outputs:
- FETCH: ALUSrcB=01, IRWrite=MemReady, PCWrite=MemReady.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-017 FETCH SHALL remain in FETCH while MemReady=0 and go to DECODE when MemReady=1; MEMRD and MEMWR SHALL hold the same way.
REQ-018 DECODE SHALL go to: MEMADR for LW or SW; EXECUTE for R-type; BRANCH for BEQ; ADDIEX for ADDI; JUMP for J; FETCH for any other opcode, with IllegalOp=1 for that cycle.
REQ-019 Other transitions:
- MEMADR -> MEMRD (LW) or MEMWR (SW).
- MEMRD -> MEMWB (on MemReady).
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR (on MemReady), ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
REQ-020 InstrDone SHALL be 1 in: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR when MemReady=1.
REQ-021 Opcode SHALL be sampled only in DECODE and MEMADR; changes at other times SHALL have no effect.
REQ-022 Cycle counts with MemReady held at 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
REQ-023 MemWrite SHALL stay at 1 for every cycle spent in MEMWR, including wait cycles.

Reset
REQ-024 While rst=1, the state SHALL be FETCH, asynchronously, and all registered state SHALL be cleared.
REQ-025 Reset in the middle of an instruction SHALL abandon it; no pending RegWrite, MemWrite or PCWrite SHALL assert after reset.
REQ-026 The first cycle after reset is released SHALL be FETCH, with outputs per REQ-016.

Structure
REQ-027 A shared package mc_ctrl_pkg SHALL hold the state encoding (4-bit), the opcode constants and the ALUOp codes 00, 01 and 10.
REQ-028 The output decode SHALL be one combinational sub-module, mc_ctrl_decode (state + MemReady -> outputs); the state register and next-state logic SHALL remain in multicycle_control.

Verification
REQ-029 Reset then LW (100011) with MemReady=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; InstrDone in cycle 5.
REQ-030 SW with MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles; InstrDone only in the final cycle; then FETCH.
REQ-031 R-type -> ALUOp=10 in EXECUTE, RegDst=1 in ALUWB; BEQ -> ALUOp=01, Branch=1, PCSrc=01, in a 3-cycle instruction.
REQ-032 Opcode 111111 -> IllegalOp=1 in DECODE, then FETCH; no RegWrite, MemWrite or PCWrite in DECODE.
REQ-033 FETCH with MemReady=0 for 2 cycles -> IRWrite=0 and PCWrite=0 in those cycles, both 1 in the ready cycle.
REQ-034 rst asserted mid-cycle while in MEMWR -> state is FETCH and MemWrite=0 immediately, before the next clock edge.
